compare_debounce_fsm: RTL and testbench

Downstream consumer of the 4-bit magnitude comparator. It takes the comparator's three relation flags once per valid cycle and filters them into a debounced relation state (below, equal, above). A relation change is accepted only after DEBOUNCE consecutive valid samples agree. The block counts entries into each state and reports illegal flag combinations, so control logic can act on a stable A-versus-B relation instead of raw per-cycle flags.

---
 rtl/compare_debounce_fsm.sv | 144 ++++++++++++++
 tb/tb_compare_debounce_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/compare_debounce_fsm.sv
// compare_debounce_fsm
// Filters the magnitude comparator's per-cycle relation flags into a stable,
// debounced relation (LT / EQ / GT), counts entries into each relation and
// flags illegal flag vectors. All outputs are registered.
module compare_debounce_fsm #(
  parameter int unsigned DEBOUNCE = 3,  // agreeing valid samples to switch, 1..15
  parameter int unsigned CNT_W    = 8   // width of each entry counter
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             A_gt_B,
  input  logic             A_eq_B,
  input  logic             A_lt_B,
  input  logic             clear,
  output logic [1:0]       state_o,
  output logic             changed_o,
  output logic             err_o,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
);

  // Encoding doubles as the state_o output code.
  typedef enum logic [1:0] {
    REL_UNK = 2'b00,
    REL_LT  = 2'b01,
    REL_EQ  = 2'b10,
    REL_GT  = 2'b11
  } rel_e;

  // Counter slots, indexed by relation.
  localparam int unsigned IDX_LT = 0;
  localparam int unsigned IDX_EQ = 1;
  localparam int unsigned IDX_GT = 2;

  localparam logic [3:0]       RUN_DONE = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  rel_e       state_q, state_n;
  rel_e       cand_q,  cand_n;
  logic [3:0] run_q,   run_n;
  logic       changed_n, err_n;

  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_n [3];
  logic [2:0]       inc;

  rel_e       cls;
  logic       legal;
  logic [3:0] run_upd;

  // Classify the raw flag vector; anything not one-hot is illegal.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    cls   = REL_UNK;
    legal = 1'b0;
    case ({A_gt_B, A_eq_B, A_lt_B})
      3'b100:  begin cls = REL_GT; legal = 1'b1; end
      3'b010:  begin cls = REL_EQ; legal = 1'b1; end
      3'b001:  begin cls = REL_LT; legal = 1'b1; end
      default: begin cls = REL_UNK; legal = 1'b0; end
    endcase
  end

  // Debounce next-state: track a candidate run, commit when it reaches DEBOUNCE.
  always_comb begin
    state_n   = state_q;
    cand_n    = cand_q;
    run_n     = run_q;
    changed_n = 1'b0;
    err_n     = 1'b0;
    inc       = 3'b000;
    run_upd   = 4'd0;
    if (in_valid) begin
      if (!legal) begin
        err_n = 1'b1;
        run_n = 4'd0;
      end else if (cls == state_q) begin
        // Agreement with the current relation discards any pending noise.
        run_n = 4'd0;
      end else begin
        if (cls == cand_q) begin
          run_upd = run_q + 4'd1;
        end else begin
          cand_n  = cls;
          run_upd = 4'd1;
        end
        if (run_upd == RUN_DONE) begin
          state_n   = cls;
          changed_n = 1'b1;
          run_n     = 4'd0;
          case (cls)
            REL_LT:  inc[IDX_LT] = 1'b1;
            REL_EQ:  inc[IDX_EQ] = 1'b1;
            default: inc[IDX_GT] = 1'b1;
          endcase
        end else begin
          run_n = run_upd;
        end
      end
    end
  end

  // Entry counters: clear wins over increment, increments saturate.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_n[i] = cnt_q[i];
      if (clear) begin
        cnt_n[i] = '0;
      end else if (inc[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_n[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State, run tracking, pulses and counters; synchronous reset dominates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= REL_UNK;
      cand_q    <= REL_UNK;
      run_q     <= 4'd0;
      changed_o <= 1'b0;
      err_o     <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_n;
      cand_q    <= cand_n;
      run_q     <= run_n;
      changed_o <= changed_n;
      err_o     <= err_n;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_n[i];
    end
  end

  assign state_o = state_q;
  assign lt_cnt  = cnt_q[IDX_LT];
  assign eq_cnt  = cnt_q[IDX_EQ];
  assign gt_cnt  = cnt_q[IDX_GT];

endmodule

// File: tb/tb_compare_debounce_fsm.sv
// Testbench for compare_debounce_fsm: directed vectors with hand-computed
// expectations pushed into a scoreboard queue and checked by a monitor.
module tb_compare_debounce_fsm;

  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_EQ = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;
  localparam logic [1:0] S_UNK = 2'b00;
  localparam logic [1:0] S_LT  = 2'b01;
  localparam logic [1:0] S_EQ  = 2'b10;
  localparam logic [1:0] S_GT  = 2'b11;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic in_valid = 1'b0;
  logic a_gt = 1'b0, a_eq = 1'b0, a_lt = 1'b0;
  logic clear = 1'b0;

  logic [1:0] st0, st1;
  logic       ch0, ch1, er0, er1;
  logic [7:0] lt0, eq0, gt0;
  logic [1:0] lt1, eq1, gt1;

  always #5 clk = ~clk;

  compare_debounce_fsm #(.DEBOUNCE(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst0), .in_valid(in_valid),
    .A_gt_B(a_gt), .A_eq_B(a_eq), .A_lt_B(a_lt), .clear(clear),
    .state_o(st0), .changed_o(ch0), .err_o(er0),
    .lt_cnt(lt0), .eq_cnt(eq0), .gt_cnt(gt0)
  );

  compare_debounce_fsm #(.DEBOUNCE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(in_valid),
    .A_gt_B(a_gt), .A_eq_B(a_eq), .A_lt_B(a_lt), .clear(clear),
    .state_o(st1), .changed_o(ch1), .err_o(er1),
    .lt_cnt(lt1), .eq_cnt(eq1), .gt_cnt(gt1)
  );

  typedef struct {
    bit         which;
    string      name;
    logic [1:0] st;
    logic       ch;
    logic       er;
    logic [7:0] lt, eq, gt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sel = 1'b0;

  // Drive one cycle of inputs and queue the response expected after that edge.
  task automatic step(input string name, input logic v, input logic [2:0] f,
                      input logic clr, input logic [1:0] st, input logic ch,
                      input logic er, input logic [7:0] l, input logic [7:0] e,
                      input logic [7:0] g);
    exp_t x;
    in_valid = v;
    {a_gt, a_eq, a_lt} = f;
    clear = clr;
    @(posedge clk);
    x.which = sel; x.name = name; x.st = st; x.ch = ch; x.er = er;
    x.lt = l; x.eq = e; x.gt = g;
    q.push_back(x);
    #1;
  endtask

  // One reset cycle on the selected DUT; valid and clear are held high to show rst dominates.
  task automatic reset_cycle(input string name);
    if (sel) rst1 = 1'b1; else rst0 = 1'b1;
    step(name, 1'b1, F_GT, 1'b1, S_UNK, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    if (sel) rst1 = 1'b0; else rst0 = 1'b0;
  endtask

  // Monitor: after each edge, pop and compare the response the stimulus expected.
  initial begin
    exp_t x;
    logic [1:0] a_st;
    logic       a_ch, a_er;
    logic [7:0] a_lt, a_eq, a_gt;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        if (x.which) begin
          a_st = st1; a_ch = ch1; a_er = er1;
          a_lt = {6'd0, lt1}; a_eq = {6'd0, eq1}; a_gt = {6'd0, gt1};
        end else begin
          a_st = st0; a_ch = ch0; a_er = er0;
          a_lt = lt0; a_eq = eq0; a_gt = gt0;
        end
        checks++;
        if (a_st !== x.st || a_ch !== x.ch || a_er !== x.er ||
            a_lt !== x.lt || a_eq !== x.eq || a_gt !== x.gt) begin
          errors++;
          $display("FAIL %s: got st=%b ch=%b err=%b lt=%0d eq=%0d gt=%0d, want st=%b ch=%b err=%b lt=%0d eq=%0d gt=%0d",
                   x.name, a_st, a_ch, a_er, a_lt, a_eq, a_gt,
                   x.st, x.ch, x.er, x.lt, x.eq, x.gt);
        end
      end
    end
  end

  // Watchdog: the directed sequence is short; anything this long is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] el, eg;
    // ---------------- main DUT: DEBOUNCE=3, CNT_W=8 ----------------
    sel = 1'b0;
    reset_cycle("reset_a");
    reset_cycle("reset_b");
    step("eq_entry_1", 1, F_EQ, 0, S_UNK, 0, 0, 0, 0, 0);
    step("eq_entry_2", 1, F_EQ, 0, S_UNK, 0, 0, 0, 0, 0);
    step("eq_entry_3", 1, F_EQ, 0, S_EQ,  1, 0, 0, 1, 0);

    // Glitch rejection: GT GT EQ GT GT stays EQ, third GT commits.
    step("glitch_gt1", 1, F_GT, 0, S_EQ, 0, 0, 0, 1, 0);
    step("glitch_gt2", 1, F_GT, 0, S_EQ, 0, 0, 0, 1, 0);
    step("glitch_eq",  1, F_EQ, 0, S_EQ, 0, 0, 0, 1, 0);
    step("glitch_gt3", 1, F_GT, 0, S_EQ, 0, 0, 0, 1, 0);
    step("glitch_gt4", 1, F_GT, 0, S_EQ, 0, 0, 0, 1, 0);
    step("glitch_gt5", 1, F_GT, 0, S_GT, 1, 0, 0, 1, 1);

    // Valid gaps do not break the LT run.
    step("gap_lt1", 1, F_LT, 0, S_GT, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++)
      step("gap_idle", 0, 3'b000, 0, S_GT, 0, 0, 0, 1, 1);
    step("gap_lt2", 1, F_LT, 0, S_GT, 0, 0, 0, 1, 1);
    step("gap_lt3", 1, F_LT, 0, S_LT, 1, 0, 1, 1, 1);

    // Back to EQ, then an illegal vector restarts the LT run.
    step("ill_eq1", 1, F_EQ, 0, S_LT, 0, 0, 1, 1, 1);
    step("ill_eq2", 1, F_EQ, 0, S_LT, 0, 0, 1, 1, 1);
    step("ill_eq3", 1, F_EQ, 0, S_EQ, 1, 0, 1, 2, 1);
    step("ill_lt1", 1, F_LT, 0, S_EQ, 0, 0, 1, 2, 1);
    step("ill_lt2", 1, F_LT, 0, S_EQ, 0, 0, 1, 2, 1);
    step("ill_110", 1, 3'b110, 0, S_EQ, 0, 1, 1, 2, 1);
    step("ill_lt3", 1, F_LT, 0, S_EQ, 0, 0, 1, 2, 1);
    step("ill_lt4", 1, F_LT, 0, S_EQ, 0, 0, 1, 2, 1);
    step("ill_lt5", 1, F_LT, 0, S_LT, 1, 0, 2, 2, 1);
    step("ill_000_invalid", 0, 3'b000, 0, S_LT, 0, 0, 2, 2, 1);
    step("ill_110_invalid", 0, 3'b110, 0, S_LT, 0, 0, 2, 2, 1);
    step("ill_111", 1, 3'b111, 0, S_LT, 0, 1, 2, 2, 1);
    step("ill_000", 1, 3'b000, 0, S_LT, 0, 1, 2, 2, 1);
    step("ill_after", 1, F_LT, 0, S_LT, 0, 0, 2, 2, 1);

    // Reset mid-run discards the pending GT run.
    step("mid_eq1", 1, F_EQ, 0, S_LT, 0, 0, 2, 2, 1);
    step("mid_eq2", 1, F_EQ, 0, S_LT, 0, 0, 2, 2, 1);
    step("mid_eq3", 1, F_EQ, 0, S_EQ, 1, 0, 2, 3, 1);
    step("mid_gt1", 1, F_GT, 0, S_EQ, 0, 0, 2, 3, 1);
    step("mid_gt2", 1, F_GT, 0, S_EQ, 0, 0, 2, 3, 1);
    reset_cycle("mid_reset");
    step("mid_gt3", 1, F_GT, 0, S_UNK, 0, 0, 0, 0, 0);
    step("mid_gt4", 1, F_GT, 0, S_UNK, 0, 0, 0, 0, 0);
    step("mid_gt5", 1, F_GT, 0, S_GT,  1, 0, 0, 0, 1);

    // ---------------- second DUT: DEBOUNCE=1, CNT_W=2 ----------------
    rst0 = 1'b1;
    sel  = 1'b1;
    reset_cycle("sat_reset");
    el = 8'd0;
    eg = 8'd0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        if (el != 8'd3) el = el + 8'd1;
        step("sat_lt", 1, F_LT, 0, S_LT, 1, 0, el, 0, eg);
      end else begin
        if (eg != 8'd3) eg = eg + 8'd1;
        step("sat_gt", 1, F_GT, 0, S_GT, 1, 0, el, 0, eg);
      end
    end
    step("sat_lt_final", 1, F_LT, 0, S_LT, 1, 0, 3, 0, 3);
    step("clear_with_gt", 1, F_GT, 1, S_GT, 1, 0, 0, 0, 0);
    step("after_clear",   1, F_GT, 0, S_GT, 0, 0, 0, 0, 0);
    step("d1_eq_switch",  1, F_EQ, 0, S_EQ, 1, 0, 0, 1, 0);

    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
